gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
- Iterative greatest-common-divisor unit for two unsigned operands.
- Uses subtraction-based Euclid, one subtraction per clock.
- A one-cycle START pulse launches a computation. DONE pulses for one cycle with the result on Y, or with ERROR set when an operand is zero.
- Standalone arithmetic accelerator driven by a simple start/done handshake.

Parameters:
WIDTH, 8, operand and result bit width (all arithmetic unsigned).

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
A  input  WIDTH  operand A; sampled on the START edge only
B  input  WIDTH  operand B; sampled on the START edge only
START  input  1  request; sampled high at a rising edge while IDLE launches a computation
Y  output  WIDTH  GCD result; valid only while DONE=1, otherwise 0
DONE  output  1  one-cycle completion pulse
ERROR  output  1  high with DONE when A==0 or B==0; otherwise 0

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset state: FSM in IDLE; internal regs ra, rb = 0; Y=0, DONE=0, ERROR=0.
- Reset mid-operation aborts immediately with the same values; no DONE is produced for the aborted request.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, CALC, FINISH.
- IDLE:
  - On a rising edge with START=1: ra<=A, rb<=B, go to CALC.
  - START=0: stay in IDLE.
- CALC, evaluated each cycle in priority order:
  1. ra==0 or rb==0: go to FINISH with error flag set, result 0.
  2. ra==rb: go to FINISH with result ra.
  3. ra>rb: ra<=ra-rb, stay in CALC.
  4. Otherwise: rb<=rb-ra, stay in CALC.
- FINISH: go to IDLE on the next edge.
- Output timing:
  - DONE=1, Y=result and ERROR=flag appear on the edge that enters FINISH.
  - They stay valid for exactly one cycle, then return to 0 on the edge back to IDLE.
- START while in CALC or FINISH is ignored, not queued; A and B are not resampled.
- START held high continuously relaunches at the first edge back in IDLE.
- Latency, counted from the START edge to the edge raising DONE, is (number of subtractions + 2) cycles:
  - zero operand: 2 cycles;
  - A==B: 2 cycles;
  - 21,6: 6 cycles;
  - worst case 255,1: 256 cycles.
- Subtraction never underflows, since the larger operand is always reduced.
- Result is always between 1 and 2^WIDTH-1 when ERROR=0.
- DONE must drop for at least one cycle between completions, so every completion produces a distinct rising DONE edge.

Test Plan:
- Reset: assert RST_N=0 mid-CALC (A=250, B=255) -> Y=0, DONE=0, ERROR=0 immediately; after release, no DONE until the next START.
- Basic: START with A=21, B=6 -> DONE pulse 6 cycles later, Y=3, ERROR=0. A=8, B=17 -> Y=1. A=128, B=120 -> Y=8. A=128, B=110 -> Y=2. A=250, B=255 -> Y=5.
- Equal/multiple: A=42, B=42 -> Y=42 after 2 cycles. A=64, B=128 -> Y=64.
- Error: (35,0), (0,42), (0,0) -> DONE pulse after 2 cycles with ERROR=1, Y=0.
- Handshake: pulse START with A=21, B=6, then change A/B and pulse START again during CALC -> result still 3; the second START is ignored. DONE high exactly one cycle, Y=0 otherwise.
- Back-to-back: issue the next START one cycle after each DONE across all vectors above -> each completes with the correct Y and ERROR; worst case (255,1) -> Y=1 after 256 cycles.

Source files
------------

// File: rtl/gcd_if.sv
// Start/done bundle between a requester and the GCD engine.
// Operands and start are driven by the master; result, done and error by the slave.
interface gcd_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic [WIDTH-1:0] y;
    logic             done;
    logic             error;

    // Handshake: start is sampled only while the engine is idle, and a and b are
    // captured on that same edge. done pulses for exactly one cycle. y and error
    // are meaningful only while done is high; at every other time they read 0.
    // A start seen while the engine is busy is dropped, not queued.
    modport master (
        output a, b, start,
        input  y, done, error
    );

    modport slave (
        input  a, b, start,
        output y, done, error
    );
endinterface

// File: rtl/gcd_engine.sv
// Subtraction-based Euclid GCD, one subtraction per clock, with a start/done handshake.
// All outputs are registered; zero operands finish with error set and y = 0.
module gcd_engine #(
    parameter int WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    gcd_if.slave       bus,
    output logic [1:0] dbg_state
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        y_d     = '0;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    state_d = CALC;
                end
            end
            CALC: begin
                // The zero test must come first: with a zero operand the
                // subtraction loop would never converge.
                if (ra_q == '0 || rb_q == '0) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else if (ra_q == rb_q) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    y_d     = ra_q;
                end else if (ra_q > rb_q) begin
                    ra_d = ra_q - rb_q;
                end else begin
                    rb_d = rb_q - ra_q;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            y_q     <= y_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.done  = done_q;
    assign bus.error = error_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: hand-computed GCD vectors, latency, pulse shape,
// ignored mid-run start, back-to-back launches and asynchronous reset.
module tb_gcd_engine;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;

  gcd_if #(.WIDTH(8)) gi ();

  gcd_engine #(.WIDTH(8)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .bus       (gi),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Call at a negedge with the engine idle. Cycles are counted with the START
  // edge as cycle 1, so a zero operand completes in 2 and (21,6) in 6.
  // With poke set, a second start carrying other operands is pulsed mid-run.
  task automatic run_gcd(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_y, input logic exp_err,
                         input int exp_lat, input bit poke);
    int   cyc;
    bit   got;
    bit   y_leak;
    string tag;
    tag      = $sformatf("gcd(%0d,%0d)", a, b);
    gi.a     = a;
    gi.b     = b;
    gi.start = 1'b1;
    cyc      = 0;
    got      = 1'b0;
    y_leak   = 1'b0;
    while (cyc < 400 && !got) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (poke && cyc == 2) begin
        gi.a     = 8'd100;
        gi.b     = 8'd7;
        gi.start = 1'b1;
      end else begin
        gi.start = 1'b0;
      end
      if (gi.done) got = 1'b1;
      else if (gi.y != 8'd0 || gi.error) y_leak = 1'b1;
    end
    check_eq({tag, " done_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      check_eq({tag, " y"},       {24'd0, gi.y}, {24'd0, exp_y});
      check_eq({tag, " error"},   {31'd0, gi.error}, {31'd0, exp_err});
      check_eq({tag, " latency"}, cyc, exp_lat);
      check_eq({tag, " idle_outputs_zero"}, {31'd0, y_leak}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, " done_one_cycle"}, {31'd0, gi.done}, 32'd0);
      check_eq({tag, " y_after_done"},   {24'd0, gi.y}, 32'd0);
    end
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int quiet_done;
    checks   = 0;
    failures = 0;
    gi.a     = '0;
    gi.b     = '0;
    gi.start = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset y",     {24'd0, gi.y}, 32'd0);
    check_eq("reset done",  {31'd0, gi.done}, 32'd0);
    check_eq("reset error", {31'd0, gi.error}, 32'd0);
    check_eq("reset state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // a, b, gcd, error, latency (subtractions + 2)
    vecs.push_back('{8'd21,  8'd6,   8'd3,  1'b0, 6});
    vecs.push_back('{8'd8,   8'd17,  8'd1,  1'b0, 11});
    vecs.push_back('{8'd128, 8'd120, 8'd8,  1'b0, 17});
    vecs.push_back('{8'd128, 8'd110, 8'd2,  1'b0, 17});
    vecs.push_back('{8'd250, 8'd255, 8'd5,  1'b0, 52});
    vecs.push_back('{8'd42,  8'd42,  8'd42, 1'b0, 2});
    vecs.push_back('{8'd64,  8'd128, 8'd64, 1'b0, 3});
    vecs.push_back('{8'd35,  8'd0,   8'd0,  1'b1, 2});
    vecs.push_back('{8'd0,   8'd42,  8'd0,  1'b1, 2});
    vecs.push_back('{8'd0,   8'd0,   8'd0,  1'b1, 2});
    vecs.push_back('{8'd255, 8'd1,   8'd1,  1'b0, 256});

    // Back-to-back: each run returns one cycle after DONE, already idle.
    foreach (vecs[i]) run_gcd(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].err, vecs[i].lat, 1'b0);

    // Second start during CALC is ignored; operands are not resampled.
    run_gcd(8'd21, 8'd6, 8'd3, 1'b0, 6, 1'b1);

    // Reset mid-CALC aborts with all outputs low.
    gi.a = 8'd250; gi.b = 8'd255; gi.start = 1'b1;
    @(posedge clk); @(negedge clk); gi.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midcalc state_before", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midcalc reset state", {30'd0, dbg_state}, 32'd0);
    check_eq("midcalc reset done",  {31'd0, gi.done}, 32'd0);
    check_eq("midcalc reset y",     {24'd0, gi.y}, 32'd0);
    check_eq("midcalc reset error", {31'd0, gi.error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (gi.done) quiet_done++;
    end
    check_eq("no done after abort", quiet_done, 0);

    // Reset landing while DONE is high clears it without waiting for a clock.
    gi.a = 8'd42; gi.b = 8'd42; gi.start = 1'b1;
    @(posedge clk); @(negedge clk); gi.start = 1'b0;
    @(posedge clk); #2;
    check_eq("done before async reset", {31'd0, gi.done}, 32'd1);
    check_eq("y before async reset",    {24'd0, gi.y}, 32'd42);
    rst_n = 1'b0;
    #1;
    check_eq("async reset done", {31'd0, gi.done}, 32'd0);
    check_eq("async reset y",    {24'd0, gi.y}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Engine still works after the resets.
    run_gcd(8'd128, 8'd110, 8'd2, 1'b0, 17, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
